// File: rtl/vend_pkg.sv
// Shared types and default parameters for the vending controller slice.
package vend_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CREDIT,
        S_DISPENSE,
        S_WAIT_TAKE,
        S_CHANGE
    } state_t;

    localparam int DEFAULT_MAX_CREDIT  = 200;
    localparam int DEFAULT_CHANGE_UNIT = 5;

endpackage

// File: rtl/vend_if.sv
// Coin acceptor, button panel, dispenser and change-hopper signals of the vending controller.
interface vend_if #(
    parameter int N_SEL    = 4,
    parameter int CREDIT_W = 8
);
    localparam int SEL_W = (N_SEL > 1) ? $clog2(N_SEL) : 1;

    logic                      coin_valid;
    logic [CREDIT_W-1:0]       coin_value;
    logic                      coin_reject;
    logic                      cancel;
    logic [N_SEL-1:0]          sel_req;
    logic [N_SEL*CREDIT_W-1:0] price;
    logic [CREDIT_W-1:0]       credit;
    logic                      flash;
    logic                      insufficient;
    logic                      disp_req;
    logic [SEL_W-1:0]          disp_sel;
    logic                      disp_ack;
    logic                      received;
    logic                      change_req;
    logic                      change_ack;

    // The controller owns the dispense and change requests, so it is the master side.
    modport master (
        input  coin_valid, coin_value, cancel, sel_req, price, disp_ack, received, change_ack,
        output coin_reject, credit, flash, insufficient, disp_req, disp_sel, change_req
    );

    modport slave (
        output coin_valid, coin_value, cancel, sel_req, price, disp_ack, received, change_ack,
        input  coin_reject, credit, flash, insufficient, disp_req, disp_sel, change_req
    );

endinterface

// File: rtl/vend_controller_rr_arbiter.sv
// Round-robin selection among request lines, searching upward from the slot after ptr.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          update,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic [IW-1:0] ptr_next
);

    logic          found;
    logic [IW-1:0] cand;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    // Granted or refused, the winner becomes the new "last served" slot.
    assign ptr_next = (update && found) ? idx : ptr;

endmodule

// File: rtl/vend_controller.sv
// Credit accumulation, round-robin product selection, dispense and change-payout sequencing.
module vend_controller
    import vend_pkg::*;
#(
    parameter int N_SEL       = 4,
    parameter int CREDIT_W    = 8,
    parameter int MAX_CREDIT  = DEFAULT_MAX_CREDIT,
    parameter int CHANGE_UNIT = DEFAULT_CHANGE_UNIT
) (
    input  logic   clk,
    input  logic   resetn,
    vend_if.master bus
);

    localparam int                  SEL_W   = (N_SEL > 1) ? $clog2(N_SEL) : 1;
    localparam logic [CREDIT_W-1:0] UNIT    = CREDIT_W'(CHANGE_UNIT);
    localparam logic [CREDIT_W:0]   CEILING = (CREDIT_W + 1)'(MAX_CREDIT);

    state_t              state;
    logic [CREDIT_W-1:0] credit;
    logic                flash;
    logic                coin_reject;
    logic                insufficient;
    logic                disp_req;
    logic                change_req;
    logic [SEL_W-1:0]    disp_sel;
    logic [SEL_W-1:0]    rr_ptr;
    logic [SEL_W-1:0]    rr_ptr_next;
    logic [SEL_W-1:0]    win_idx;
    logic [N_SEL-1:0]    win_grant;
    logic [CREDIT_W-1:0] slot_price [N_SEL];
    logic [CREDIT_W-1:0] win_price;
    logic [CREDIT_W-1:0] credit_coin;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fits;
    logic                sel_any;
    logic                arb_update;

    always_comb begin
        for (int i = 0; i < N_SEL; i++) begin
            slot_price[i] = bus.price[i*CREDIT_W +: CREDIT_W];
        end
    end

    // One extra bit on the sum so an oversize coin is refused instead of wrapping.
    assign coin_sum    = {1'b0, credit} + {1'b0, bus.coin_value};
    assign coin_fits   = (coin_sum <= CEILING);
    assign credit_coin = (bus.coin_valid && coin_fits) ? coin_sum[CREDIT_W-1:0] : credit;

    assign arb_update = (state == S_CREDIT) && !bus.cancel;
    assign sel_any    = |win_grant;
    assign win_price  = slot_price[win_idx];

    rr_arbiter #(
        .N  (N_SEL),
        .IW (SEL_W)
    ) u_arb (
        .req      (bus.sel_req),
        .ptr      (rr_ptr),
        .update   (arb_update),
        .grant    (win_grant),
        .idx      (win_idx),
        .ptr_next (rr_ptr_next)
    );

    // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            credit       <= '0;
            flash        <= 1'b1;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
            disp_req     <= 1'b0;
            disp_sel     <= '0;
            change_req   <= 1'b0;
            rr_ptr       <= '0;
        end else begin
            coin_reject  <= bus.coin_valid &&
                            !(state == S_IDLE || (state == S_CREDIT && coin_fits));
            insufficient <= 1'b0;
            rr_ptr       <= rr_ptr_next;

            case (state)
                S_IDLE: begin
                    if (bus.coin_valid) begin
                        credit <= bus.coin_value;
                        flash  <= 1'b0;
                        state  <= S_CREDIT;
                    end
                end

                // Affordability uses the credit held before this cycle's coin lands.
                S_CREDIT: begin
                    if (bus.cancel) begin
                        credit <= credit_coin;
                        state  <= S_CHANGE;
                    end else if (sel_any && (win_price <= credit)) begin
                        credit   <= credit_coin - win_price;
                        disp_sel <= win_idx;
                        disp_req <= 1'b1;
                        state    <= S_DISPENSE;
                    end else begin
                        insufficient <= sel_any;
                        credit       <= credit_coin;
                    end
                end

                S_DISPENSE: begin
                    if (bus.disp_ack) begin
                        disp_req <= 1'b0;
                        state    <= S_WAIT_TAKE;
                    end
                end

                S_WAIT_TAKE: begin
                    if (bus.received) begin
                        if (credit >= UNIT) begin
                            state <= S_CHANGE;
                        end else begin
                            credit <= '0;
                            flash  <= 1'b1;
                            state  <= S_IDLE;
                        end
                    end
                end

                // Request drops for one cycle after each ack, then re-arms while a unit remains.
                S_CHANGE: begin
                    if (change_req) begin
                        if (bus.change_ack) begin
                            credit     <= credit - UNIT;
                            change_req <= 1'b0;
                        end
                    end else if (credit >= UNIT) begin
                        change_req <= 1'b1;
                    end else begin
                        credit <= '0;
                        flash  <= 1'b1;
                        state  <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.credit       = credit;
    assign bus.flash        = flash;
    assign bus.coin_reject  = coin_reject;
    assign bus.insufficient = insufficient;
    assign bus.disp_req     = disp_req;
    assign bus.disp_sel     = disp_sel;
    assign bus.change_req   = change_req;

endmodule
